// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between two mux sources and the select arbiter.
// master = requester side, slave = arbiter; lock exists only with MUX_SEL_ARB_LOCK_EN.
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic sel;
    logic grant_a;
    logic grant_b;
    logic switch_p;
`ifdef MUX_SEL_ARB_LOCK_EN
    logic lock;

    modport master (
        output req_a, req_b, lock,
        input  sel, grant_a, grant_b, switch_p
    );
    modport slave (
        input  req_a, req_b, lock,
        output sel, grant_a, grant_b, switch_p
    );
`else
    modport master (
        output req_a, req_b,
        input  sel, grant_a, grant_b, switch_p
    );
    modport slave (
        input  req_a, req_b,
        output sel, grant_a, grant_b, switch_p
    );
`endif
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-way round-robin select arbiter for a 2:1 mux; optional lock input via MUX_SEL_ARB_LOCK_EN.
// Latency: request sampled at edge N is visible as grant/sel from edge N; all outputs registered.
// Backpressure: none; a waiting requester is served after at most MAX_HOLD cycles of the owner.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_sel_arbiter_if.slave  bus
);
    localparam int              CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  hold_cnt;
    logic           last_b;
    logic           sel_q;
    logic           sel_nxt;
    logic           grant_a_q;
    logic           grant_b_q;
    logic           switch_q;
    logic           lock_w;
    logic           expire;

`ifdef MUX_SEL_ARB_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    // Handover on hold expiry only; lock only matters while a grant is held.
    assign expire = (hold_cnt == HOLD_LAST) && !lock_w;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_a && bus.req_b)
                    state_nxt = last_b ? GNT_A : GNT_B;
                else if (bus.req_a)
                    state_nxt = GNT_A;
                else if (bus.req_b)
                    state_nxt = GNT_B;
                else
                    state_nxt = IDLE;
            end
            GNT_A: begin
                if (!bus.req_a)
                    state_nxt = bus.req_b ? GNT_B : IDLE;
                else if (bus.req_b && expire)
                    state_nxt = GNT_B;
                else
                    state_nxt = GNT_A;
            end
            GNT_B: begin
                if (!bus.req_b)
                    state_nxt = bus.req_a ? GNT_A : IDLE;
                else if (bus.req_a && expire)
                    state_nxt = GNT_A;
                else
                    state_nxt = GNT_B;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IDLE keeps the previous select so the mux path does not move needlessly.
    always_comb begin
        sel_nxt = sel_q;
        if (state_nxt == GNT_A)
            sel_nxt = 1'b0;
        else if (state_nxt == GNT_B)
            sel_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            switch_q  <= 1'b0;
            hold_cnt  <= '0;
            last_b    <= 1'b1;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            grant_a_q <= (state_nxt == GNT_A);
            grant_b_q <= (state_nxt == GNT_B);
            switch_q  <= (sel_nxt != sel_q);

            if (state_nxt != state)
                hold_cnt <= '0;
            else if ((state != IDLE) && !lock_w && (hold_cnt != HOLD_LAST))
                hold_cnt <= hold_cnt + CW'(1);

            if (state_nxt == GNT_B)
                last_b <= 1'b1;
            else if (state_nxt == GNT_A)
                last_b <= 1'b0;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant_a  = grant_a_q;
    assign bus.grant_b  = grant_b_q;
    assign bus.switch_p = switch_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances driven with the same requests,
// checked every cycle against an owner/run-length model plus directed literal expectations.
module tb_mux_sel_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ra  = 1'b1;
    logic rb  = 1'b1;

    always #5 clk = ~clk;

    mux_sel_arbiter_if bus4();
    mux_sel_arbiter_if bus1();

    assign bus4.req_a = ra;
    assign bus4.req_b = rb;
    assign bus1.req_a = ra;
    assign bus1.req_b = rb;
`ifdef MUX_SEL_ARB_LOCK_EN
    assign bus4.lock = 1'b0;
    assign bus1.lock = 1'b0;
`endif

    mux_sel_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=A 2=B; run = consecutive granted cycles of the current owner.
    int mh[2]         = '{4, 1};
    int owner[2]      = '{0, 0};
    int run[2]        = '{0, 0};
    int m_sel[2]      = '{0, 0};
    int m_sw[2]       = '{0, 0};
    int last_was_b[2] = '{1, 1};

    task automatic model_step(input int i, input logic r, input logic a, input logic b);
        int no;
        int ns;
        if (r) begin
            owner[i] = 0; run[i] = 0; m_sel[i] = 0; m_sw[i] = 0; last_was_b[i] = 1;
            return;
        end
        no = owner[i];
        case (owner[i])
            0: begin
                if (a && b)  no = last_was_b[i] ? 1 : 2;
                else if (a)  no = 1;
                else if (b)  no = 2;
                else         no = 0;
            end
            1: begin
                if (!a)                        no = b ? 2 : 0;
                else if (b && run[i] >= mh[i]) no = 2;
                else                           no = 1;
            end
            default: begin
                if (!b)                        no = a ? 1 : 0;
                else if (a && run[i] >= mh[i]) no = 1;
                else                           no = 2;
            end
        endcase
        if (no == 0)             run[i] = 0;
        else if (no == owner[i]) run[i] = (run[i] < 1000) ? run[i] + 1 : 1000;
        else                     run[i] = 1;
        ns = (no == 1) ? 0 : (no == 2) ? 1 : m_sel[i];
        m_sw[i]  = (ns != m_sel[i]) ? 1 : 0;
        m_sel[i] = ns;
        if (no == 2) last_was_b[i] = 1;
        if (no == 1) last_was_b[i] = 0;
        owner[i] = no;
    endtask

    always @(posedge clk) begin
        model_step(0, rst, ra, rb);
        model_step(1, rst, ra, rb);
        #1;
        chk("m4_sel",     bus4.sel,      m_sel[0] == 1);
        chk("m4_grant_a", bus4.grant_a,  owner[0] == 1);
        chk("m4_grant_b", bus4.grant_b,  owner[0] == 2);
        chk("m4_switch",  bus4.switch_p, m_sw[0] == 1);
        chk("m4_excl",    bus4.grant_a & bus4.grant_b, 1'b0);
        chk("m1_sel",     bus1.sel,      m_sel[1] == 1);
        chk("m1_grant_a", bus1.grant_a,  owner[1] == 1);
        chk("m1_grant_b", bus1.grant_b,  owner[1] == 2);
        chk("m1_switch",  bus1.switch_p, m_sw[1] == 1);
        chk("m1_excl",    bus1.grant_a & bus1.grant_b, 1'b0);
    end

    task automatic step(input logic a, input logic b, input logic r);
        @(negedge clk);
        ra = a; rb = b; rst = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with both requesting.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_sel",     bus4.sel,      1'b0);
        chk("rst_grant_a", bus4.grant_a,  1'b0);
        chk("rst_grant_b", bus4.grant_b,  1'b0);
        chk("rst_switch",  bus4.switch_p, 1'b0);

        // Fairness: A wins first tie, then blocks of MAX_HOLD.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("fair4_grant_a", bus4.grant_a,  ((k / 4) % 2) == 0);
            chk("fair4_grant_b", bus4.grant_b,  ((k / 4) % 2) == 1);
            chk("fair4_switch",  bus4.switch_p, (k % 4 == 0) && (k > 0));
            chk("fair1_grant_a", bus1.grant_a,  (k % 2) == 0);
            chk("fair1_switch",  bus1.switch_p, k > 0);
        end

        // Lone requester B keeps the grant; dropping it leaves sel at 1 with no pulse.
        step(1'b0, 1'b0, 1'b0);
        chk("idle_sel_kept", bus4.sel, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("lone_grant_b", bus4.grant_b, 1'b1);
            chk("lone_sel",     bus4.sel,     1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("lone_drop_grant_b", bus4.grant_b,  1'b0);
        chk("lone_drop_sel",     bus4.sel,      1'b1);
        chk("lone_drop_switch",  bus4.switch_p, 1'b0);

        // Early release from GNT_A at hold 1.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("early_pre_grant_a", bus4.grant_a, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("early_grant_b", bus4.grant_b,  1'b1);
        chk("early_switch",  bus4.switch_p, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("early_switch_end", bus4.switch_p, 1'b0);

        // Reset in GNT_B at hold 2, then A wins the first tie again.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("midrst_sel",     bus4.sel,      1'b0);
        chk("midrst_grant_b", bus4.grant_b,  1'b0);
        chk("midrst_switch",  bus4.switch_p, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("midrst_tie_a", bus4.grant_a, 1'b1);

        // Random phase: long request bursts and occasional reset.
        for (int k = 0; k < 3000; k++) begin
            logic na;
            logic nb;
            logic nr;
            na = ($urandom_range(0, 9) < 7) ? ra : ~ra;
            nb = ($urandom_range(0, 9) < 7) ? rb : ~rb;
            nr = ($urandom_range(0, 199) == 0);
            step(na, nb, nr);
        end

        step(1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
